// File: rtl/m_imem_loader.sv
// rtl/m_imem_loader.sv - length-prefixed byte-stream loader that fills imem while holding the CPU in halt
// Optional trailing 32-bit word checksum is enabled by defining LOADER_CHECKSUM_EN.
module m_imem_loader #(
    parameter int ADDR_W = 11
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_start,
    input  logic [7:0]        w_rx_data,
    input  logic              w_rx_valid,
    output logic              r_rx_ready,
    output logic              r_mem_we,
    output logic [ADDR_W-1:0] r_mem_addr,
    output logic [31:0]       r_mem_din,
    output logic              r_cpu_halt,
    output logic              r_busy,
    output logic              r_done,
    output logic              r_err
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE, S_CSUM} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE} state_t;
`endif

    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       shift_q, shift_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [31:0]       sum_q, sum_d;

    logic              rx_ready_q, rx_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_din_q, mem_din_d;
    logic              halt_q, halt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              fire;
    logic              last_byte;
    logic [31:0]       asm_word;
    logic [ADDR_W:0]   idx_inc;
    logic              enter_done;

    // Bytes arrive LSB first, so each new byte enters at the top and slides down.
    assign fire      = w_rx_valid && rx_ready_q;
    assign last_byte = fire && (cnt_q == 2'd3);
    assign asm_word  = {w_rx_data, shift_q[31:8]};
    assign idx_inc   = idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        n_d        = n_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        rx_ready_d = rx_ready_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        halt_d     = halt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        enter_done = 1'b0;

        if (fire) begin
            shift_d = asm_word;
            cnt_d   = cnt_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    state_d    = S_HDR;
                    busy_d     = 1'b1;
                    halt_d     = 1'b1;
                    rx_ready_d = 1'b1;
                    err_d      = 1'b0;
                    idx_d      = '0;
                    cnt_d      = 2'd0;
                    sum_d      = '0;
                end
            end
            S_HDR: begin
                if (last_byte) begin
                    if (asm_word == 32'd0) begin
                        enter_done = 1'b1;
                    end else if (asm_word > CAPACITY) begin
                        enter_done = 1'b1;
                        err_d      = 1'b1;
                    end else begin
                        n_d     = asm_word[ADDR_W:0];
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (last_byte) begin
                    state_d    = S_WRITE;
                    mem_we_d   = 1'b1;
                    mem_din_d  = asm_word;
                    mem_addr_d = idx_q[ADDR_W-1:0];
                    rx_ready_d = 1'b0;
                    sum_d      = sum_q + asm_word;
                end
            end
            S_WRITE: begin
                idx_d = idx_inc;
                if (idx_inc == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d    = S_CSUM;
                    rx_ready_d = 1'b1;
`else
                    enter_done = 1'b1;
`endif
                end else begin
                    state_d    = S_DATA;
                    rx_ready_d = 1'b1;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (last_byte) begin
                    enter_done = 1'b1;
                    err_d      = (asm_word != sum_q);
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_done) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            halt_d     = 1'b0;
            rx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            shift_q    <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            rx_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            halt_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            rx_ready_q <= rx_ready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            halt_q     <= halt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign r_rx_ready = rx_ready_q;
    assign r_mem_we   = mem_we_q;
    assign r_mem_addr = mem_addr_q;
    assign r_mem_din  = mem_din_q;
    assign r_cpu_halt = halt_q;
    assign r_busy     = busy_q;
    assign r_done     = done_q;
    assign r_err      = err_q;

endmodule

// File: tb/tb_m_imem_loader.sv
// tb/tb_m_imem_loader.sv - directed self-checking bench for m_imem_loader
// Checksum stimulus is included when LOADER_CHECKSUM_EN is defined.
module tb_m_imem_loader;

    localparam int ADDR_W = 11;

    logic              w_clk = 1'b0;
    logic              w_rst;
    logic              w_start;
    logic [7:0]        w_rx_data;
    logic              w_rx_valid;
    logic              r_rx_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_din;
    logic              r_cpu_halt;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          we_cnt   = 0;
    int          we_base;
    logic        toggle_mode;
    logic [31:0] mem_m [0:2047];

    m_imem_loader #(.ADDR_W(ADDR_W)) dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .w_start    (w_start),
        .w_rx_data  (w_rx_data),
        .w_rx_valid (w_rx_valid),
        .r_rx_ready (r_rx_ready),
        .r_mem_we   (r_mem_we),
        .r_mem_addr (r_mem_addr),
        .r_mem_din  (r_mem_din),
        .r_cpu_halt (r_cpu_halt),
        .r_busy     (r_busy),
        .r_done     (r_done),
        .r_err      (r_err)
    );

    always #5 w_clk = ~w_clk;

    // imem model: captures every write strobe seen mid-cycle
    always @(negedge w_clk) begin
        if (r_mem_we === 1'b1) begin
            mem_m[r_mem_addr] = r_mem_din;
            we_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge w_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        if (toggle_mode) begin
            w_rx_valid = 1'b0;
            tick;
        end
        w_rx_data  = b;
        w_rx_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (r_rx_ready === 1'b1) begin
                got = 1'b1;
                chk("halt_during_load", r_cpu_halt, 1'b1);
            end
            tick;
        end
        chk("byte_accepted", {31'd0, got}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic start_load;
        w_start = 1'b1;
        tick;
        w_start = 1'b0;
        chk("start_busy", r_busy, 1'b1);
        chk("start_halt", r_cpu_halt, 1'b1);
        chk("start_ready", r_rx_ready, 1'b1);
    endtask

    // Called in the last WRITE cycle; returns in the DONE cycle.
    task automatic finish_load(input logic [31:0] csum);
        tick;
`ifdef LOADER_CHECKSUM_EN
        send_word(csum);
`else
        if (csum == 32'hFFFF_FFFF) chk("unused_csum", 32'd0, 32'd1);
`endif
    endtask

    task automatic chk_write(input string tag, input logic [31:0] addr, input logic [31:0] din);
        chk({tag, "_we"}, r_mem_we, 1'b1);
        chk({tag, "_addr"}, r_mem_addr, addr);
        chk({tag, "_din"}, r_mem_din, din);
        chk({tag, "_ready0"}, r_rx_ready, 1'b0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, r_rx_ready, 1'b0);
        chk({tag, "_we"}, r_mem_we, 1'b0);
        chk({tag, "_addr"}, r_mem_addr, 32'd0);
        chk({tag, "_din"}, r_mem_din, 32'd0);
        chk({tag, "_halt"}, r_cpu_halt, 1'b0);
        chk({tag, "_busy"}, r_busy, 1'b0);
        chk({tag, "_done"}, r_done, 1'b0);
        chk({tag, "_err"}, r_err, 1'b0);
    endtask

    task automatic load_two(input string tag);
        mem_m[0] = 32'd0;
        mem_m[1] = 32'd0;
        we_base  = we_cnt;
        start_load;
        send_word(32'd2);
        send_word(32'h1234_5678);
        chk_write({tag, "_w0"}, 32'd0, 32'h1234_5678);
        send_word(32'hDEAD_BEEF);
        chk_write({tag, "_w1"}, 32'd1, 32'hDEAD_BEEF);
        chk({tag, "_halt_wr"}, r_cpu_halt, 1'b1);
        finish_load(32'h1234_5678 + 32'hDEAD_BEEF);
        chk({tag, "_done"}, r_done, 1'b1);
        chk({tag, "_err"}, r_err, 1'b0);
        chk({tag, "_halt_rel"}, r_cpu_halt, 1'b0);
        chk({tag, "_busy_rel"}, r_busy, 1'b0);
        w_rx_valid = 1'b0;
        tick;
        chk({tag, "_done_pulse"}, r_done, 1'b0);
        chk({tag, "_mem0"}, mem_m[0], 32'h1234_5678);
        chk({tag, "_mem1"}, mem_m[1], 32'hDEAD_BEEF);
        chk({tag, "_we_count"}, we_cnt - we_base, 32'd2);
    endtask

    initial begin
        w_rst       = 1'b1;
        w_start     = 1'b0;
        w_rx_data   = 8'h00;
        w_rx_valid  = 1'b0;
        toggle_mode = 1'b0;
        for (int i = 0; i < 2048; i++) mem_m[i] = 32'd0;
        tick;
        tick;
        chk_idle_outputs("reset");
        w_rst = 1'b0;
        tick;

        load_two("held");

        toggle_mode = 1'b1;
        load_two("toggle");
        toggle_mode = 1'b0;

        // oversize header
        we_base = we_cnt;
        start_load;
        send_word(32'h0000_0801);
        chk("hdr_err_done", r_done, 1'b1);
        chk("hdr_err_err", r_err, 1'b1);
        w_rx_valid = 1'b0;
        tick;
        chk("hdr_err_held", r_err, 1'b1);
        chk("hdr_err_busy", r_busy, 1'b0);
        chk("hdr_err_nowrite", we_cnt - we_base, 32'd0);

        // empty load
        start_load;
        chk("n0_err_cleared", r_err, 1'b0);
        send_word(32'd0);
        chk("n0_done", r_done, 1'b1);
        chk("n0_err", r_err, 1'b0);
        w_rx_valid = 1'b0;
        tick;
        chk("n0_nowrite", we_cnt - we_base, 32'd0);

        // start pulse mid-DATA must be ignored
        start_load;
        send_word(32'd1);
        send_byte(8'hEF);
        send_byte(8'hBE);
        w_rx_valid = 1'b0;
        w_start    = 1'b1;
        tick;
        w_start = 1'b0;
        chk("midstart_busy", r_busy, 1'b1);
        send_byte(8'hAD);
        send_byte(8'hDE);
        chk_write("midstart_w0", 32'd0, 32'hDEAD_BEEF);
        finish_load(32'hDEAD_BEEF);
        chk("midstart_done", r_done, 1'b1);
        chk("midstart_err", r_err, 1'b0);
        w_rx_valid = 1'b0;
        tick;
        chk("midstart_idle", r_busy, 1'b0);
        chk("midstart_mem0", mem_m[0], 32'hDEAD_BEEF);

        // reset in the middle of DATA
        start_load;
        send_word(32'd3);
        send_byte(8'h11);
        send_byte(8'h22);
        w_rx_data = 8'h33;
        w_rst     = 1'b1;
        tick;
        chk_idle_outputs("midrst");
        we_base = we_cnt;
        tick;
        tick;
        w_rst = 1'b0;
        repeat (5) tick;
        chk("midrst_nowrite", we_cnt - we_base, 32'd0);
        chk("midrst_busy", r_busy, 1'b0);
        start_load;
        send_word(32'd1);
        send_word(32'hCAFE_BABE);
        chk_write("restart_w0", 32'd0, 32'hCAFE_BABE);
        finish_load(32'hCAFE_BABE);
        chk("restart_done", r_done, 1'b1);
        chk("restart_err", r_err, 1'b0);
        w_rx_valid = 1'b0;
        tick;
        chk("restart_mem0", mem_m[0], 32'hCAFE_BABE);

`ifdef LOADER_CHECKSUM_EN
        start_load;
        send_word(32'd1);
        send_word(32'd5);
        tick;
        send_word(32'd5);
        chk("csum_ok_done", r_done, 1'b1);
        chk("csum_ok_err", r_err, 1'b0);
        w_rx_valid = 1'b0;
        tick;
        mem_m[0] = 32'd0;
        start_load;
        send_word(32'd1);
        send_word(32'd5);
        tick;
        send_word(32'd6);
        chk("csum_bad_done", r_done, 1'b1);
        chk("csum_bad_err", r_err, 1'b1);
        w_rx_valid = 1'b0;
        tick;
        chk("csum_bad_mem0", mem_m[0], 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
